// File: rtl/target_centroid_pkg.sv
// Shared constants and FSM encoding for the target centroid block and the steering stage.
// Geometry defaults describe the full ISP frame; the goal point is the frame centre.
package target_centroid_pkg;

    localparam int unsigned CENTROID_W     = 1024;
    localparam int unsigned CENTROID_H     = 768;
    localparam int unsigned WIDTH_X        = 11;
    localparam int unsigned WIDTH_Y        = 11;
    localparam int unsigned GOAL_X         = CENTROID_W / 2;
    localparam int unsigned GOAL_Y         = CENTROID_H / 2;
    localparam int unsigned MIN_PIXELS_DEF = 16;
    localparam int unsigned SUM_W_DEF      = 30;
    localparam int unsigned CNT_W_DEF      = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/target_centroid_if.sv
// Pixel-stream input and centroid output bundle of the target centroid block.
// master = pixel source / steering side, slave = target_centroid.
interface target_centroid_if;
    import target_centroid_pkg::*;

    logic               pix_valid;
    logic               pix_bit;
    logic               sof;
    logic [WIDTH_X-1:0] x;
    logic [WIDTH_Y-1:0] y;
    logic               coord_valid;
    logic               target_found;
    logic               busy;

    modport master (
        output pix_valid, pix_bit, sof,
        input  x, y, coord_valid, target_found, busy
    );

    modport slave (
        input  pix_valid, pix_bit, sof,
        output x, y, coord_valid, target_found, busy
    );

endinterface

// File: rtl/target_centroid_seq_divider.sv
// Restoring divider, one quotient bit per cycle for SUM_W cycles after start.
// done pulses for one cycle once the quotient is final; it then holds until the next start.
module target_centroid_seq_divider #(
    parameter int unsigned SUM_W = 30,
    parameter int unsigned CNT_W = 20,
    parameter int unsigned Q_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int unsigned STEP_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0]  quo;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  den;
    logic [STEP_W-1:0] steps;
    logic              run;
    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    diff;

    // rem < den always, so the MSB of diff is a clean borrow flag
    always_comb begin
        trial = {rem, quo[SUM_W-1]};
        diff  = trial - {1'b0, den};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo   <= '0;
            rem   <= '0;
            den   <= '0;
            steps <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo   <= dividend;
                rem   <= '0;
                den   <= divisor;
                steps <= STEP_W'(SUM_W);
                run   <= 1'b1;
            end else if (run) begin
                if (!diff[CNT_W]) begin
                    rem <= diff[CNT_W-1:0];
                    quo <= {quo[SUM_W-2:0], 1'b1};
                end else begin
                    rem <= trial[CNT_W-1:0];
                    quo <= {quo[SUM_W-2:0], 1'b0};
                end
                steps <= steps - 1'b1;
                if (steps == STEP_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo[Q_W-1:0];

endmodule

// File: rtl/target_centroid.sv
// Per-frame target centroid from the binarized pixel stream, feeding the steering stage.
// Build option TARGET_CENTROID_HOLD_LAST_EN: lost target keeps last x/y instead of the goal point.
//
// state    | meaning
// ST_IDLE  | waiting for a frame-end snapshot
// ST_DIV_X | divider running sum_x / cnt
// ST_DIV_Y | divider running sum_y / cnt
// ST_DONE  | outputs registered, coord_valid high for this cycle
module target_centroid
    import target_centroid_pkg::*;
#(
    parameter int unsigned W          = CENTROID_W,
    parameter int unsigned H          = CENTROID_H,
    parameter int unsigned MIN_PIXELS = MIN_PIXELS_DEF,
    parameter int unsigned SUM_W      = SUM_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    target_centroid_if.slave cif
);

    localparam int unsigned COL_W   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned ROW_W   = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned MIN_EFF = (MIN_PIXELS < 1) ? 1 : MIN_PIXELS;
    localparam int unsigned Q_W     = (WIDTH_X > WIDTH_Y) ? WIDTH_X : WIDTH_Y;
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(W - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(H - 1);
    localparam logic [WIDTH_X-1:0] GOAL_XV  = WIDTH_X'(W / 2);
    localparam logic [WIDTH_Y-1:0] GOAL_YV  = WIDTH_Y'(H / 2);

    logic [COL_W-1:0]   col, pos_col;
    logic [ROW_W-1:0]   row, pos_row;
    logic               hit, last_pix, restart, frame_end_q;
    logic [SUM_W-1:0]   acc_x, acc_y, snap_y;
    logic [CNT_W-1:0]   acc_cnt, snap_cnt;

    state_t             state, state_nxt;
    logic               snap_take, take_x, load_out, lost;
    logic               div_start, div_done;
    logic [SUM_W-1:0]   div_num;
    logic [CNT_W-1:0]   div_den;
    logic [Q_W-1:0]     div_quo;
    logic [WIDTH_X-1:0] quo_x, x_q;
    logic [WIDTH_Y-1:0] y_q;
    logic               found_q;

    // a sof pixel is pinned to the frame origin regardless of the running raster
    always_comb begin
        pos_col  = cif.sof ? '0 : col;
        pos_row  = cif.sof ? '0 : row;
        hit      = cif.pix_valid && cif.pix_bit;
        last_pix = cif.pix_valid && (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        restart  = (cif.pix_valid && cif.sof) || frame_end_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col         <= '0;
            row         <= '0;
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= last_pix;
            if (cif.pix_valid) begin
                if (pos_col == COL_LAST) begin
                    col <= '0;
                    row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_x   <= '0;
            acc_y   <= '0;
            acc_cnt <= '0;
        end else begin
            acc_x   <= (restart ? '0 : acc_x) + (hit ? SUM_W'(pos_col) : '0);
            acc_y   <= (restart ? '0 : acc_y) + (hit ? SUM_W'(pos_row) : '0);
            acc_cnt <= (restart ? '0 : acc_cnt) + CNT_W'(hit);
        end
    end

    // X is divided straight from the accumulators; only Y and cnt need holding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_y   <= '0;
            snap_cnt <= '0;
        end else if (snap_take) begin
            snap_y   <= acc_y;
            snap_cnt <= acc_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        snap_take = 1'b0;
        take_x    = 1'b0;
        load_out  = 1'b0;
        lost      = 1'b0;
        div_start = 1'b0;
        div_num   = acc_x;
        div_den   = acc_cnt;
        case (state)
            ST_IDLE: begin
                if (frame_end_q) begin
                    snap_take = 1'b1;
                    if (acc_cnt >= CNT_W'(MIN_EFF)) begin
                        div_start = 1'b1;
                        state_nxt = ST_DIV_X;
                    end else begin
                        lost      = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DIV_X: begin
                div_num = snap_y;
                div_den = snap_cnt;
                if (div_done) begin
                    take_x    = 1'b1;
                    div_start = 1'b1;
                    state_nxt = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (div_done) begin
                    load_out  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    target_centroid_seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_x   <= '0;
            x_q     <= GOAL_XV;
            y_q     <= GOAL_YV;
            found_q <= 1'b0;
        end else begin
            if (take_x) quo_x <= div_quo[WIDTH_X-1:0];
            if (load_out) begin
                x_q     <= quo_x;
                y_q     <= div_quo[WIDTH_Y-1:0];
                found_q <= 1'b1;
            end else if (lost) begin
                found_q <= 1'b0;
`ifdef TARGET_CENTROID_HOLD_LAST_EN
`else
                x_q     <= GOAL_XV;
                y_q     <= GOAL_YV;
`endif
            end
        end
    end

    assign cif.x            = x_q;
    assign cif.y            = y_q;
    assign cif.target_found = found_q;
    assign cif.coord_valid  = (state == ST_DONE);
    assign cif.busy         = (state == ST_DIV_X) || (state == ST_DIV_Y);

endmodule

// File: tb/tb_target_centroid.sv
// Directed bench for target_centroid on a reduced 32x24 frame to keep runtime short.
// Expected centroids are hand-computed from the rectangle sums; lost-target values follow the build option.
module tb_target_centroid;
    import target_centroid_pkg::*;

    localparam int TW  = 32;
    localparam int TH  = 24;
    localparam int GX  = TW / 2;
    localparam int GY  = TH / 2;
    localparam int LAT = 63;

    logic clk;
    logic reset;
    int   cyc, last_cyc;
    int   cv_count, cv_cyc, cv_x, cv_y, cv_tf;
    int   n_tests, n_fail;
    int   exp_x, exp_y;
    int   base;

    target_centroid_if cif();

    target_centroid #(
        .W          (TW),
        .H          (TH),
        .MIN_PIXELS (16),
        .SUM_W      (30),
        .CNT_W      (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        cv_count = 0; cv_cyc = 0; cv_x = 0; cv_y = 0; cv_tf = 0;
    end

    always @(negedge clk) begin
        if (cif.coord_valid) begin
            cv_count++;
            cv_cyc = cyc;
            cv_x   = int'(cif.x);
            cv_y   = int'(cif.y);
            cv_tf  = int'(cif.target_found);
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rectangle [cx0..cx1] x [ry0..ry1] is target; drop_one removes its top-left pixel
    task automatic send_frame(input int cx0, input int cx1, input int ry0, input int ry1,
                              input int n_rows, input bit drop_one);
        for (int r = 0; r < n_rows; r++) begin
            for (int c = 0; c < TW; c++) begin
                @(negedge clk);
                cif.pix_valid = 1'b1;
                cif.sof       = (r == 0) && (c == 0);
                cif.pix_bit   = (c >= cx0) && (c <= cx1) && (r >= ry0) && (r <= ry1)
                                && !(drop_one && (r == ry0) && (c == cx0));
                last_cyc = cyc;
            end
        end
        @(negedge clk);
        cif.pix_valid = 1'b0;
        cif.sof       = 1'b0;
        cif.pix_bit   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_lost();
`ifdef TARGET_CENTROID_HOLD_LAST_EN
`else
        exp_x = GX;
        exp_y = GY;
`endif
    endtask

    task automatic check_result(input string tag, input int tf);
        check_val({tag, "_pulses"}, cv_count - base, 1);
        check_val({tag, "_x"}, cv_x, exp_x);
        check_val({tag, "_y"}, cv_y, exp_y);
        check_val({tag, "_found"}, cv_tf, tf);
        check_val({tag, "_busy_idle"}, int'(cif.busy), 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        exp_x = GX; exp_y = GY;
        last_cyc = 0;
        reset = 1'b0;
        cif.pix_valid = 1'b0;
        cif.pix_bit   = 1'b0;
        cif.sof       = 1'b0;

        idle(3);
        check_val("rst_x", int'(cif.x), GX);
        check_val("rst_y", int'(cif.y), GY);
        check_val("rst_cv", int'(cif.coord_valid), 0);
        check_val("rst_found", int'(cif.target_found), 0);
        check_val("rst_busy", int'(cif.busy), 0);
        reset = 1'b1;
        idle(3);

        // 4x4 block: x = 184/16 = 11, y = 104/16 = 6, exactly MIN_PIXELS
        base = cv_count;
        send_frame(10, 13, 5, 8, TH, 1'b0);
        while (cyc < last_cyc + 10) @(negedge clk);
        check_val("blk_busy_running", int'(cif.busy), 1);
        idle(100);
        exp_x = 11; exp_y = 6;
        check_result("blk", 1);
        check_val("blk_latency", cv_cyc - (last_cyc + 1), LAT);

        base = cv_count;
        send_frame(1, 0, 1, 0, TH, 1'b0);
        idle(100);
        expect_lost();
        check_result("empty", 0);

        base = cv_count;
        send_frame(10, 13, 5, 8, TH, 1'b1);
        idle(100);
        expect_lost();
        check_result("px15", 0);

        // partial frame cut by a fresh sof at row 16, then 5x5 block centred on (20,18)
        base = cv_count;
        send_frame(2, 5, 10, 13, 16, 1'b0);
        send_frame(18, 22, 16, 20, TH, 1'b0);
        check_val("abort_no_pulse", cv_count - base, 0);
        idle(100);
        exp_x = 20; exp_y = 18;
        check_result("abort_next", 1);

        // full white: x = 11904/768 = 15, y = 8832/768 = 11
        base = cv_count;
        send_frame(0, TW - 1, 0, TH - 1, TH, 1'b0);
        idle(100);
        exp_x = 15; exp_y = 11;
        check_result("white", 1);
        check_val("white_latency", cv_cyc - (last_cyc + 1), LAT);

        // reset asserted while DIV_Y runs
        base = cv_count;
        send_frame(10, 13, 5, 8, TH, 1'b0);
        while (cyc < last_cyc + 46) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rstdiv_x", int'(cif.x), GX);
        check_val("rstdiv_y", int'(cif.y), GY);
        check_val("rstdiv_busy", int'(cif.busy), 0);
        check_val("rstdiv_found", int'(cif.target_found), 0);
        idle(2);
        reset = 1'b1;
        idle(100);
        check_val("rstdiv_no_pulse", cv_count - base, 0);
        exp_x = GX; exp_y = GY;

        base = cv_count;
        send_frame(18, 22, 16, 20, TH, 1'b0);
        idle(100);
        exp_x = 20; exp_y = 18;
        check_result("after_rst", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/target_centroid.md
Name: target_centroid

Overview:
- Upstream feeder of the dual-servo steering stage.
- Consumes the binarized ISP pixel stream: one mask bit per pixel, 1 = target pixel.
- Accumulates target pixel coordinates over a frame, then divides sequentially to produce the target centroid.
- Drives the x/y coordinate inputs of the steering stage, with an update pulse once per frame.

Parameters:
- W, 1024, active pixels per line
- H, 768, active lines per frame
- MIN_PIXELS, 16, minimum target pixel count for a valid detection
- WIDTH_x, 11, x output width
- WIDTH_y, 11, y output width
- SUM_W, 30, accumulator width; must hold (W-1)*W*H
- CNT_W, 20, pixel-count width; must hold W*H

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_valid  in  1  one active pixel this cycle
- pix_bit  in  1  binarized pixel (1 = target)
- sof  in  1  start-of-frame; coincides with the first pix_valid of a frame
- x  out  WIDTH_x  centroid column
- y  out  WIDTH_y  centroid row
- coord_valid  out  1  one-cycle pulse when x/y update
- target_found  out  1  last completed frame had ≥MIN_PIXELS target pixels
- busy  out  1  divider running

Behaviour:
- Reset: x=W/2, y=H/2, coord_valid=0, target_found=0, busy=0; counters, accumulators and FSM cleared to IDLE.
- Raster position:
  - col/row counters advance on pix_valid.
  - col wraps W-1→0 and row increments on wrap.
- sof:
  - On a sof cycle with pix_valid, the pixel is treated as col=0,row=0.
  - Accumulators restart with that pixel's contribution.
  - A sof before the previous frame completes discards the partial frame; no output is produced for it.
- Accumulation: on pix_valid && pix_bit, sum_x+=col, sum_y+=row, cnt+=1.
- Frame end:
  - Triggered by the valid pixel at col=W-1,row=H-1.
  - On the next cycle, sum_x/sum_y/cnt are snapshotted into divider registers and the accumulators clear.
  - The next frame can accumulate immediately.
- FSM states IDLE → DIV_X → DIV_Y → DONE → IDLE:
  - IDLE:
    - On snapshot with cnt≥MIN_PIXELS, go to DIV_X and set busy=1.
    - On snapshot with cnt<MIN_PIXELS, go to DONE with target_found=0 and the lost-target outputs (see Optional Feature).
  - DIV_X: restoring divider sum_x/cnt, SUM_W cycles; quotient truncated.
  - DIV_Y: same for sum_y/cnt.
  - DONE:
    - Register x, y, target_found=1, coord_valid=1 for one cycle, busy=0.
    - Return to IDLE.
- Latency: frame-end pixel to coord_valid = 2*SUM_W+3 cycles (63 at default).
- Arithmetic:
  - Quotient ≤W-1 / ≤H-1 by construction; the low WIDTH bits are taken.
  - cnt=0 is never divided; it is covered by the MIN_PIXELS gate, with MIN_PIXELS≥1 enforced.
- Snapshot while busy: the new snapshot is dropped and the current division completes. Blanking is normally ≫ latency, so this is a fault case only.
- x/y hold their value between coord_valid pulses.
- Asynchronous reset mid-division aborts it and forces all reset values.

Optional Feature:
- Macro: TARGET_CENTROID_HOLD_LAST_EN.
- Defined: on a lost target (cnt<MIN_PIXELS), x/y keep their previous values; coord_valid still pulses and target_found=0.
- Undefined: on a lost target, x=W/2, y=H/2 (goal position, servo deadband); coord_valid pulses and target_found=0.

Decomposition:
- Shared package holds W, H, WIDTH_x, WIDTH_y, the goal constants W/2 and H/2, and the FSM state encoding; these are shared with the steering stage.
- Sub-module seq_divider:
  - Parameterized SUM_W/CNT_W restoring divider.
  - start/done handshake; quotient output.
  - Instanced once and shared by X and Y.

Test Plan:
- Single 4×4 target block at cols 100-103, rows 200-203 (16 pixels) → x=101, y=201, target_found=1, coord_valid 63 cycles after the last pixel.
- Empty frame → coord_valid pulse, target_found=0, x=512,y=384 (macro off). With macro on after the previous test: x=101, y=201.
- 15-pixel target (MIN_PIXELS=16) → treated as lost; same response as the empty frame.
- sof reasserted mid-frame at row 300 → no coord_valid for the aborted frame; the next full frame with a target at (600,500) gives x=600,y=500.
- Full-white frame → x=511, y=383. Checks accumulator width with no overflow.
- reset low during DIV_Y → x=512, y=384, busy=0, no coord_valid; the next frame computes correctly.
